// File: rtl/parking_pkg.sv
// Shared types and 7-segment helpers for the parking-lot day logger.
// Segment encodings are active-low, bit0 = segment a.
package parking_pkg;

    typedef enum logic {
        DAY    = 1'b0,
        REPLAY = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_F    = 7'h0E;
    localparam logic [6:0] SEG_U    = 7'h41;
    localparam logic [6:0] SEG_L    = 7'h47;

    // Decimal digit to segments; codes above 9 blank the display.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hour_log_mem.sv
// Hourly entry log: single write port, registered read port.
// The array itself is never reset; only the read register is.
module hour_log_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/parking_lot_logger.sv
// Parking-lot day datapath: occupancy, hourly entry logging, first rush
// window capture and end-of-day replay of the log on six 7-segment digits.
module parking_lot_logger
    import parking_pkg::*;
#(
    parameter int unsigned NUM_SPOTS = 3,
    parameter int unsigned NUM_HOURS = 8,
    parameter int unsigned ENT_W     = 4,
    parameter int unsigned HOUR_W    = 4,
    parameter int unsigned CNT_W     = $clog2(NUM_SPOTS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              car_enter,
    input  logic              car_exit,
    input  logic              hour_tick,
    input  logic              replay_tick,
    output logic [CNT_W-1:0]  spots_left,
    output logic              full,
    output logic [HOUR_W-1:0] hour,
    output logic              day_done,
    output logic              rush_valid,
    output logic [HOUR_W-1:0] rush_start_hour,
    output logic [HOUR_W-1:0] rush_end_hour,
    output logic [HOUR_W-1:0] replay_addr,
    output logic [ENT_W-1:0]  replay_count,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5
);

    localparam int unsigned MEM_AW = (NUM_HOURS > 1) ? $clog2(NUM_HOURS) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_SPOTS);
    localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(NUM_HOURS - 1);
    localparam logic [ENT_W-1:0]  ENT_MAX   = '1;

    // Any field value wider than a digit is blanked when above 9.
    function automatic logic [6:0] to_seg(input logic [31:0] v);
        return (v > 32'd9) ? SEG_OFF : digit_to_seg(v[3:0]);
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   spots_left_q, spots_left_d;
    logic               full_q, full_d;
    logic               day_done_q, day_done_d;
    logic [HOUR_W-1:0]  hour_q, hour_d;
    logic [ENT_W-1:0]   entries_q, entries_d;
    logic               rush_started_q, rush_started_d;
    logic               rush_valid_q, rush_valid_d;
    logic [HOUR_W-1:0]  rush_start_q, rush_start_d;
    logic [HOUR_W-1:0]  rush_end_q, rush_end_d;
    logic [HOUR_W-1:0]  replay_addr_q, replay_addr_d;
    logic [6:0]         hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;
    logic [6:0]         hex0_d, hex1_d, hex2_d, hex3_d, hex4_d, hex5_d;

    logic               in_day;
    logic               enter_ok;
    logic               exit_ok;
    logic               mem_we;
    logic [ENT_W-1:0]   mem_wdata;
    logic [ENT_W-1:0]   mem_rdata;

    assign in_day   = (state_q == DAY);
    // A full lot still admits a car when one leaves in the same cycle.
    assign enter_ok = in_day && car_enter && ((occ_q != FULL_CNT) || car_exit);
    assign exit_ok  = in_day && car_exit && (occ_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DAY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == DAY) && hour_tick && (hour_q == LAST_HOUR)) begin
            state_d = REPLAY;
        end
    end

    always_comb begin
        occ_d          = occ_q;
        entries_d      = entries_q;
        hour_d         = hour_q;
        rush_started_d = rush_started_q;
        rush_valid_d   = rush_valid_q;
        rush_start_d   = rush_start_q;
        rush_end_d     = rush_end_q;
        replay_addr_d  = replay_addr_q;
        mem_we         = 1'b0;
        mem_wdata      = entries_q;

        if (!(car_enter && car_exit)) begin
            if (enter_ok) begin
                occ_d = occ_q + CNT_W'(1);
            end else if (exit_ok) begin
                occ_d = occ_q - CNT_W'(1);
            end
        end

        if (enter_ok && (entries_q != ENT_MAX)) begin
            entries_d = entries_q + ENT_W'(1);
        end

        // The hour's log word includes an entry accepted on the tick cycle.
        if (in_day && hour_tick) begin
            mem_we    = 1'b1;
            mem_wdata = entries_d;
            entries_d = '0;
            if (hour_q != LAST_HOUR) begin
                hour_d = hour_q + HOUR_W'(1);
            end
        end

        if (in_day) begin
            if ((occ_d == FULL_CNT) && !rush_started_q) begin
                rush_started_d = 1'b1;
                rush_start_d   = hour_q;
            end else if (rush_started_q && (occ_d == '0) && !rush_valid_q) begin
                rush_valid_d = 1'b1;
                rush_end_d   = hour_q;
            end
        end

        if (!in_day && replay_tick) begin
            replay_addr_d = (replay_addr_q == LAST_HOUR) ? '0 : replay_addr_q + HOUR_W'(1);
        end
    end

    assign spots_left_d = FULL_CNT - occ_d;
    assign full_d       = (occ_d == FULL_CNT);
    assign day_done_d   = (state_d == REPLAY);

    // Display images are built from the registered sources, adding one cycle.
    always_comb begin
        hex0_d = SEG_OFF;
        hex1_d = SEG_OFF;
        hex2_d = SEG_OFF;
        hex3_d = SEG_OFF;
        hex4_d = SEG_OFF;
        hex5_d = SEG_OFF;
        if (state_q == DAY) begin
            hex5_d = to_seg(32'(hour_q));
            if (full_q) begin
                hex3_d = SEG_F;
                hex2_d = SEG_U;
                hex1_d = SEG_L;
                hex0_d = SEG_L;
            end else begin
                hex0_d = to_seg(32'(spots_left_q));
            end
        end else begin
            hex1_d = to_seg(32'(mem_rdata));
            hex2_d = to_seg(32'(replay_addr_q));
            hex3_d = rush_valid_q ? to_seg(32'(rush_start_q)) : SEG_DASH;
            hex4_d = rush_valid_q ? to_seg(32'(rush_end_q)) : SEG_DASH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q          <= '0;
            spots_left_q   <= FULL_CNT;
            full_q         <= 1'b0;
            day_done_q     <= 1'b0;
            hour_q         <= '0;
            entries_q      <= '0;
            rush_started_q <= 1'b0;
            rush_valid_q   <= 1'b0;
            rush_start_q   <= '0;
            rush_end_q     <= '0;
            replay_addr_q  <= '0;
            hex0_q         <= SEG_OFF;
            hex1_q         <= SEG_OFF;
            hex2_q         <= SEG_OFF;
            hex3_q         <= SEG_OFF;
            hex4_q         <= SEG_OFF;
            hex5_q         <= SEG_OFF;
        end else begin
            occ_q          <= occ_d;
            spots_left_q   <= spots_left_d;
            full_q         <= full_d;
            day_done_q     <= day_done_d;
            hour_q         <= hour_d;
            entries_q      <= entries_d;
            rush_started_q <= rush_started_d;
            rush_valid_q   <= rush_valid_d;
            rush_start_q   <= rush_start_d;
            rush_end_q     <= rush_end_d;
            replay_addr_q  <= replay_addr_d;
            hex0_q         <= hex0_d;
            hex1_q         <= hex1_d;
            hex2_q         <= hex2_d;
            hex3_q         <= hex3_d;
            hex4_q         <= hex4_d;
            hex5_q         <= hex5_d;
        end
    end

    hour_log_mem #(
        .DEPTH (NUM_HOURS),
        .WIDTH (ENT_W),
        .AW    (MEM_AW)
    ) u_log (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (hour_q[MEM_AW-1:0]),
        .wdata (mem_wdata),
        .re    (state_q == REPLAY),
        .raddr (replay_addr_q[MEM_AW-1:0]),
        .rdata (mem_rdata)
    );

    assign spots_left      = spots_left_q;
    assign full            = full_q;
    assign hour            = hour_q;
    assign day_done        = day_done_q;
    assign rush_valid      = rush_valid_q;
    assign rush_start_hour = rush_start_q;
    assign rush_end_hour   = rush_end_q;
    assign replay_addr     = replay_addr_q;
    assign replay_count    = mem_rdata;
    assign hex0            = hex0_q;
    assign hex1            = hex1_q;
    assign hex2            = hex2_q;
    assign hex3            = hex3_q;
    assign hex4            = hex4_q;
    assign hex5            = hex5_q;

endmodule

// File: tb/tb_parking_lot_logger.sv
// Randomised and directed bench for parking_lot_logger against a
// cycle-level behavioural model of the lot, its hourly log and displays.
module tb_parking_lot_logger;

    localparam int NS = 3;
    localparam int NH = 8;
    localparam int EW = 4;
    localparam int HW = 4;
    localparam int CW = 2;
    localparam int ENT_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          car_enter = 1'b0;
    logic          car_exit = 1'b0;
    logic          hour_tick = 1'b0;
    logic          replay_tick = 1'b0;
    logic [CW-1:0] spots_left;
    logic          full;
    logic [HW-1:0] hour;
    logic          day_done;
    logic          rush_valid;
    logic [HW-1:0] rush_start_hour;
    logic [HW-1:0] rush_end_hour;
    logic [HW-1:0] replay_addr;
    logic [EW-1:0] replay_count;
    logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5;

    parking_lot_logger #(
        .NUM_SPOTS (NS),
        .NUM_HOURS (NH),
        .ENT_W     (EW),
        .HOUR_W    (HW),
        .CNT_W     (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .car_enter       (car_enter),
        .car_exit        (car_exit),
        .hour_tick       (hour_tick),
        .replay_tick     (replay_tick),
        .spots_left      (spots_left),
        .full            (full),
        .hour            (hour),
        .day_done        (day_done),
        .rush_valid      (rush_valid),
        .rush_start_hour (rush_start_hour),
        .rush_end_hour   (rush_end_hour),
        .replay_addr     (replay_addr),
        .replay_count    (replay_count),
        .hex0            (hex0),
        .hex1            (hex1),
        .hex2            (hex2),
        .hex3            (hex3),
        .hex4            (hex4),
        .hex5            (hex5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of the lot
    int m_occ, m_hour, m_entries, m_addr, m_count;
    bit m_replay, m_rs, m_rv;
    int m_rsh, m_reh;
    int m_log [NH];
    logic [6:0] e_hex [6];

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // What the displays should show one cycle after the current model state.
    task automatic model_display();
        for (int i = 0; i < 6; i++) e_hex[i] = 7'h7F;
        if (!m_replay) begin
            e_hex[5] = seg(m_hour);
            if (m_occ == NS) begin
                e_hex[3] = 7'h0E;
                e_hex[2] = 7'h41;
                e_hex[1] = 7'h47;
                e_hex[0] = 7'h47;
            end else begin
                e_hex[0] = seg(NS - m_occ);
            end
        end else begin
            e_hex[1] = seg(m_count);
            e_hex[2] = seg(m_addr);
            e_hex[3] = m_rv ? seg(m_rsh) : 7'h3F;
            e_hex[4] = m_rv ? seg(m_reh) : 7'h3F;
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_hour = 0; m_entries = 0; m_addr = 0; m_count = 0;
        m_replay = 0; m_rs = 0; m_rv = 0; m_rsh = 0; m_reh = 0;
    endtask

    task automatic model_step(input bit en, input bit ex, input bit ht, input bit rt);
        if (!m_replay) begin
            bit accepted;
            accepted = en && (m_occ < NS || ex);
            if (!(en && ex)) begin
                if (en && m_occ < NS) m_occ++;
                else if (ex && m_occ > 0) m_occ--;
            end
            if (accepted && m_entries < ENT_MAX) m_entries++;
            if (m_occ == NS && !m_rs) begin
                m_rs = 1; m_rsh = m_hour;
            end else if (m_rs && m_occ == 0 && !m_rv) begin
                m_rv = 1; m_reh = m_hour;
            end
            if (ht) begin
                m_log[m_hour] = m_entries;
                m_entries = 0;
                if (m_hour == NH - 1) m_replay = 1;
                else m_hour++;
            end
        end else begin
            m_count = m_log[m_addr];
            if (rt) m_addr = (m_addr + 1) % NH;
        end
    endtask

    task automatic compare_all();
        check("spots_left", 32'(spots_left), 32'(NS - m_occ));
        check("full", 32'(full), 32'(m_occ == NS));
        check("hour", 32'(hour), 32'(m_hour));
        check("day_done", 32'(day_done), 32'(m_replay));
        check("rush_valid", 32'(rush_valid), 32'(m_rv));
        check("rush_start_hour", 32'(rush_start_hour), 32'(m_rsh));
        check("rush_end_hour", 32'(rush_end_hour), 32'(m_reh));
        check("replay_addr", 32'(replay_addr), 32'(m_addr));
        check("replay_count", 32'(replay_count), 32'(m_count));
        check("hex0", 32'(hex0), 32'(e_hex[0]));
        check("hex1", 32'(hex1), 32'(e_hex[1]));
        check("hex2", 32'(hex2), 32'(e_hex[2]));
        check("hex3", 32'(hex3), 32'(e_hex[3]));
        check("hex4", 32'(hex4), 32'(e_hex[4]));
        check("hex5", 32'(hex5), 32'(e_hex[5]));
    endtask

    task automatic step(input bit en, input bit ex, input bit ht, input bit rt);
        @(negedge clk);
        car_enter = en; car_exit = ex; hour_tick = ht; replay_tick = rt;
        @(posedge clk);
        #1;
        model_display();
        model_step(en, ex, ht, rt);
        compare_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        car_enter = 0; car_exit = 0; hour_tick = 0; replay_tick = 0;
        #2 reset = 1'b1;
        #1;
        check("rst_hex0", 32'(hex0), 32'h7F);
        check("rst_hex1", 32'(hex1), 32'h7F);
        check("rst_hex3", 32'(hex3), 32'h7F);
        check("rst_hex5", 32'(hex5), 32'h7F);
        check("rst_day_done", 32'(day_done), 32'd0);
        check("rst_hour", 32'(hour), 32'd0);
        check("rst_spots", 32'(spots_left), 32'(NS));
        check("rst_replay_count", 32'(replay_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_random_day(input int enter_pct, input int exit_pct);
        for (int i = 0; i < 600 && !m_replay; i++) begin
            step(($urandom_range(99) < enter_pct), ($urandom_range(99) < exit_pct),
                 ($urandom_range(11) == 0), ($urandom_range(3) == 0));
        end
        check("day_reached_replay", 32'(m_replay), 32'd1);
    endtask

    int counts [NH];

    initial begin
        model_reset();
        for (int i = 0; i < NH; i++) m_log[i] = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Two arrivals then idle so the display catches up
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("plan1_spots", 32'(spots_left), 32'd1);
        check("plan1_hex0", 32'(hex0), 32'h79);
        check("plan1_hex5", 32'(hex5), 32'h40);

        // Fill during hour 2, reject a fourth car, swap while full, drain in hour 4
        do_reset();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        repeat (4) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("plan2_full", 32'(full), 32'd1);
        check("plan2_rush_start", 32'(rush_start_hour), 32'd2);
        check("plan2_hex3", 32'(hex3), 32'h0E);
        check("plan2_hex0", 32'(hex0), 32'h47);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        repeat (4) step(0, 1, 0, 0);
        check("plan4_rush_valid", 32'(rush_valid), 32'd1);
        check("plan4_rush_end", 32'(rush_end_hour), 32'd4);
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (3) step(0, 1, 0, 0);
        check("plan4_rush_end_held", 32'(rush_end_hour), 32'd4);
        run_random_day(30, 40);

        // Known hourly counts including a saturating hour, no rush
        do_reset();
        counts = '{1, 0, 3, 2, 0, 0, 1, 17};
        for (int h = 0; h < NH; h++) begin
            for (int k = 0; k < counts[h]; k++) begin
                step(1, 0, 0, 0);
                step(0, 1, 0, 0);
            end
            step(0, 0, 1, 0);
        end
        check("plan5_day_done", 32'(day_done), 32'd1);
        repeat (3) step(1, 0, 1, 0);
        for (int r = 0; r < NH + 2; r++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        while (m_addr != 7) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("plan5_sat_count", 32'(replay_count), 32'd15);
        check("plan5_hex1_off", 32'(hex1), 32'h7F);
        check("plan6_hex3_dash", 32'(hex3), 32'h3F);
        check("plan6_hex4_dash", 32'(hex4), 32'h3F);

        // Random days, each ending with a reset in the middle of replay
        for (int d = 0; d < 6; d++) begin
            do_reset();
            run_random_day(25 + 10 * (d % 3), 25 + 5 * (d % 2));
            for (int i = 0; i < 30; i++) begin
                step($urandom_range(1), $urandom_range(1), $urandom_range(1),
                     ($urandom_range(2) == 0));
            end
        end
        do_reset();
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
